// File: rtl/clk_div_monitor.sv
// Measures period and high time of a derived clock sampled in the clk domain; tracks frequency lock and stoppage.
// Optional duty-cycle check is compiled in when CLK_MON_DUTY_CHECK_EN is defined.
module clk_div_monitor #(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = 4,
    parameter int TOL        = 0,
    parameter int LOCK_CNT   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout,
    output logic [3:0]       err_cnt,
    output logic             duty_err
);
    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam int               LO_BOUND = (EXP_PERIOD > TOL) ? EXP_PERIOD - TOL : 0;
    localparam int               HI_BOUND = EXP_PERIOD + TOL;
    localparam logic [31:0]      LO_W     = 32'(LO_BOUND);
    localparam logic [31:0]      SPAN_W   = 32'(HI_BOUND - LO_BOUND);
    localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);

    state_t           state_q, state_d;
    logic             s1_q, s2_q, prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
    logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
    logic [3:0]       lock_q, lock_d, err_q, err_d;
    logic             valid_q, valid_d, locked_q, locked_d;
    logic             timeout_q, timeout_d, duty_q, duty_d;
    logic             rise, in_band, duty_bad;

    assign rise = s2_q & ~prev_q;

    // Wrap-around range check: values below LO_W wrap to a huge offset and fall out of the span.
    assign in_band = ((32'(cnt_q) - LO_W) <= SPAN_W);

`ifdef CLK_MON_DUTY_CHECK_EN
    localparam logic [CNT_W+1:0] DUTY_LIM = (CNT_W+2)'(2*TOL+1);
    logic [CNT_W+1:0] duty_diff, duty_abs;
    always_comb begin
        duty_diff = {1'b0, hcnt_q, 1'b0} - {2'b00, cnt_q};
        duty_abs  = duty_diff[CNT_W+1] ? -duty_diff : duty_diff;
        duty_bad  = (duty_abs > DUTY_LIM);
    end
`else
    assign duty_bad = 1'b0;
`endif

    always_comb begin
        cnt_d     = rise ? CNT_ONE : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);
        hcnt_d    = rise ? CNT_ONE : ((s2_q && hcnt_q != CNT_MAX) ? hcnt_q + 1'b1 : hcnt_q);
        state_d   = state_q;
        lock_d    = lock_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        timeout_d = timeout_q;
        err_d     = err_q;
        duty_d    = duty_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d   = MEASURE;
                    timeout_d = 1'b0;
                end
            end
            default: begin
                if (rise) begin
                    period_d = cnt_q;
                    high_d   = hcnt_q;
                    valid_d  = 1'b1;
                    duty_d   = duty_bad;
                    if (in_band && !duty_bad) begin
                        if (lock_q < LOCK_TGT) lock_d = lock_q + 4'd1;
                        if (lock_d == LOCK_TGT) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        lock_d   = 4'd0;
                        locked_d = 1'b0;
                        state_d  = MEASURE;
                        if (err_q != 4'hF) err_d = err_q + 4'd1;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = IDLE;
                    locked_d  = 1'b0;
                    timeout_d = 1'b1;
                    lock_d    = 4'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            prev_q    <= 1'b0;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            state_q   <= IDLE;
            lock_q    <= 4'd0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 4'd0;
            duty_q    <= 1'b0;
        end else begin
            s1_q      <= clk_in;
            s2_q      <= s1_q;
            prev_q    <= s2_q;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            state_q   <= state_d;
            lock_q    <= lock_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            duty_q    <= duty_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = valid_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;
    assign err_cnt    = err_q;
    assign duty_err   = duty_q;
endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench for clk_div_monitor: one default instance and one with TOL=1.
// Expected captures are pushed when a pulse is issued; a negedge monitor pops them on meas_valid.
module tb_clk_div_monitor;
    typedef struct {
        logic [7:0] per;
        logic [7:0] hi;
        logic       lck;
        logic [3:0] err;
        logic       duty;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   total = 0;
    int   bad   = 0;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1, rst_b = 1'b0;
    logic       clk_in_a = 1'b0, clk_in_b = 1'b0;
    logic [7:0] per_a, hi_a, per_b, hi_b;
    logic       mv_a, lck_a, to_a, duty_a, mv_b, lck_b, to_b, duty_b;
    logic [3:0] err_a, err_b;

    clk_div_monitor dut_a (
        .clk(clk), .rst(rst_a), .clk_in(clk_in_a),
        .period(per_a), .high_time(hi_a), .meas_valid(mv_a),
        .locked(lck_a), .timeout(to_a), .err_cnt(err_a), .duty_err(duty_a)
    );

    clk_div_monitor #(.TOL(1)) dut_b (
        .clk(clk), .rst(rst_b), .clk_in(clk_in_b),
        .period(per_b), .high_time(hi_b), .meas_valid(mv_b),
        .locked(lck_b), .timeout(to_b), .err_cnt(err_b), .duty_err(duty_b)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int p, input int h, input bit l, input int e, input bit d);
        exp_t r;
        r.per  = 8'(p);
        r.hi   = 8'(h);
        r.lck  = l;
        r.err  = 4'(e);
        r.duty = d;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic checkCapture(input string tag, input exp_t e, input logic [7:0] p, input logic [7:0] h,
                                input logic l, input logic [3:0] er, input logic d);
        checkOutput({tag, "_period"}, 32'(p), 32'(e.per));
        checkOutput({tag, "_high_time"}, 32'(h), 32'(e.hi));
        checkOutput({tag, "_locked"}, 32'(l), 32'(e.lck));
        checkOutput({tag, "_err_cnt"}, 32'(er), 32'(e.err));
        checkOutput({tag, "_duty_err"}, 32'(d), 32'(e.duty));
    endtask

    // Drives one clk_in period (hi cycles high, lo low) starting at a negedge; cap queues the capture this rise should produce.
    task automatic applyStimulus(input bit sel_b, input int hi, input int lo, input bit cap, input exp_t e);
        if (cap) begin
            if (sel_b) qb.push_back(e);
            else       qa.push_back(e);
        end
        if (sel_b) clk_in_b = 1'b1;
        else       clk_in_a = 1'b1;
        repeat (hi) @(negedge clk);
        if (sel_b) clk_in_b = 1'b0;
        else       clk_in_a = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mv_a === 1'b1) begin
                if (qa.size() == 0) checkOutput("a_unexpected_meas_valid", 32'(mv_a), 32'd0);
                else begin
                    e = qa.pop_front();
                    checkCapture("a", e, per_a, hi_a, lck_a, err_a, duty_a);
                end
            end
            if (mv_b === 1'b1) begin
                if (qb.size() == 0) checkOutput("b_unexpected_meas_valid", 32'(mv_b), 32'd0);
                else begin
                    e = qb.pop_front();
                    checkCapture("b", e, per_b, hi_b, lck_b, err_b, duty_b);
                end
            end
        end
    end

    initial begin
        #100000;
        bad++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int waited;
        exp_t nc;
        nc = mk(0, 0, 0, 0, 0);

        #2 rst_a = 1'b0;
        #1 checkOutput("a_reset_outputs", 32'({per_a, hi_a, mv_a, lck_a, to_a, err_a, duty_a}), 32'd0);
        repeat (2) @(negedge clk);
        rst_a = 1'b1;

        applyStimulus(0, 2, 2, 0, nc);
        applyStimulus(0, 2, 2, 1, mk(4, 2, 0, 0, 0));
        applyStimulus(0, 2, 2, 1, mk(4, 2, 0, 0, 0));
        applyStimulus(0, 2, 2, 1, mk(4, 2, 1, 0, 0));
        applyStimulus(0, 2, 2, 1, mk(4, 2, 1, 0, 0));
        applyStimulus(0, 3, 3, 1, mk(4, 2, 1, 0, 0));
        applyStimulus(0, 2, 2, 1, mk(6, 3, 0, 1, 0));
        applyStimulus(0, 2, 2, 1, mk(4, 2, 0, 1, 0));
        applyStimulus(0, 2, 2, 1, mk(4, 2, 0, 1, 0));
        applyStimulus(0, 2, 2, 1, mk(4, 2, 1, 1, 0));

        waited = 0;
        while (to_a !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("a_timeout_set", 32'(to_a), 32'd1);
        checkOutput("a_timeout_latency", 32'(waited), 32'd254);
        checkOutput("a_locked_after_timeout", 32'(lck_a), 32'd0);
        checkOutput("a_err_kept_on_timeout", 32'(err_a), 32'd1);

        applyStimulus(0, 2, 2, 0, nc);
        checkOutput("a_timeout_cleared", 32'(to_a), 32'd0);
        applyStimulus(0, 2, 2, 1, mk(4, 2, 0, 1, 0));
        applyStimulus(0, 2, 2, 1, mk(4, 2, 0, 1, 0));
        applyStimulus(0, 2, 2, 1, mk(4, 2, 1, 1, 0));
        applyStimulus(0, 2, 2, 1, mk(4, 2, 1, 1, 0));

        checkOutput("a_locked_before_reset", 32'(lck_a), 32'd1);
        rst_a = 1'b0;
        #1 checkOutput("a_midrun_reset_outputs", 32'({per_a, hi_a, mv_a, lck_a, to_a, err_a, duty_a}), 32'd0);
        repeat (2) @(negedge clk);
        rst_a = 1'b1;

        applyStimulus(0, 2, 2, 0, nc);
        applyStimulus(0, 2, 2, 1, mk(4, 2, 0, 0, 0));
        applyStimulus(0, 2, 2, 1, mk(4, 2, 0, 0, 0));
        applyStimulus(0, 2, 2, 1, mk(4, 2, 1, 0, 0));
        applyStimulus(0, 1, 3, 1, mk(4, 2, 1, 0, 0));
`ifdef CLK_MON_DUTY_CHECK_EN
        applyStimulus(0, 2, 2, 1, mk(4, 1, 0, 1, 1));
        applyStimulus(0, 2, 2, 1, mk(4, 2, 0, 1, 0));
`else
        applyStimulus(0, 2, 2, 1, mk(4, 1, 1, 0, 0));
        applyStimulus(0, 2, 2, 1, mk(4, 2, 1, 0, 0));
`endif

        rst_b = 1'b1;
        applyStimulus(1, 2, 1, 0, nc);
        applyStimulus(1, 2, 3, 1, mk(3, 2, 0, 0, 0));
        applyStimulus(1, 2, 1, 1, mk(5, 2, 0, 0, 0));
        applyStimulus(1, 2, 3, 1, mk(3, 2, 1, 0, 0));
        applyStimulus(1, 3, 3, 1, mk(5, 2, 1, 0, 0));
        applyStimulus(1, 2, 2, 1, mk(6, 3, 0, 1, 0));

        repeat (6) @(negedge clk);
        checkOutput("a_queue_drained", 32'(qa.size()), 32'd0);
        checkOutput("b_queue_drained", 32'(qb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
- Receive-side checker for divided/gated clocks produced elsewhere in the design (T-flop dividers, gated out_clk outputs).
- Samples the incoming derived clock in the system clk domain and measures its period and high time in clk cycles.
- Declares frequency lock against an expected period and flags loss or stoppage.
- Sits beside any clock-divider instance as a self-check and observability block.

Parameters:
- CNT_W, 8: width of the period/high-time counters and outputs.
- EXP_PERIOD, 4: expected period of clk_in in clk cycles.
- TOL, 0: allowed ± deviation from EXP_PERIOD, in clk cycles.
- LOCK_CNT, 3: consecutive in-band periods required to assert locked. Range 1..15.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- clk_in  in  1  monitored derived clock; asynchronous to clk, treated as data.
- period  out  CNT_W  last measured period in clk cycles.
- high_time  out  CNT_W  last measured high time in clk cycles.
- meas_valid  out  1  one-cycle pulse when period/high_time update.
- locked  out  1  frequency lock indication.
- timeout  out  1  sticky; clk_in stopped. Cleared on the next rising edge of clk_in.
- err_cnt  out  4  saturating count of out-of-band periods.
- duty_err  out  1  duty check failed; see Optional Feature.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; sync flops 0; state IDLE; counters 0.
- Sync: two-flop synchronizer s1→s2, plus prev=s2 delayed one cycle.
- Rise event: s2=1 && prev=0. It is seen 3 clk cycles after clk_in rises when clk_in is driven from clk.
- Counters:
  - cnt is loaded with 1 on every rise and increments by 1 on every other cycle.
  - hcnt is loaded with 1 on every rise; otherwise it increments when s2=1 and holds when s2=0.
  - Both saturate at all-ones.
- States:
  - IDLE: on the first rise, go to MEASURE. No capture happens on that rise. Clear timeout.
  - MEASURE / LOCKED: on every rise:
    - Capture period<=cnt and high_time<=hcnt.
    - Pulse meas_valid the same cycle the registers update (outputs visible the next cycle).
    - Evaluate the captured value: in-band if EXP_PERIOD-TOL <= cnt <= EXP_PERIOD+TOL. Use unsigned compare. If EXP_PERIOD<TOL, the lower bound clamps to 0.
    - In-band: increment the lock counter, saturating at LOCK_CNT. When it reaches LOCK_CNT, go to LOCKED and set locked=1.
    - Out-of-band: clear the lock counter, set locked=0, go to MEASURE, and increment err_cnt (saturates at 15).
  - Any state except IDLE: if cnt reaches all-ones with no rise, go to IDLE, set locked=0, set timeout=1, and clear the lock counter. err_cnt is unaffected.
- A rise on the same cycle that cnt reaches all-ones: the rise wins (normal capture, no timeout).
- Reset mid-measurement: immediate return to IDLE. The first post-reset edge is never captured.
- err_cnt is cleared only by reset.

Optional Feature:
- Macro: CLK_MON_DUTY_CHECK_EN.
- Defined:
  - On each capture, duty_err<=1 if |2*hcnt - cnt| > 2*TOL+1, computed with CNT_W+2-bit arithmetic.
  - A duty failure also counts as out-of-band for the lock logic and err_cnt.
  - duty_err updates with meas_valid and is cleared on reset.
- Not defined: duty_err is tied 0, and high_time is still reported but ignored for lock.

Test Plan:
- Lock: clk_in toggles every 2 clk cycles (period 4, high 2), defaults.
  - First meas_valid about 3+4 cycles after the first edge, with period=4 and high_time=2.
  - locked=1 after the 3rd capture; err_cnt=0.
- Frequency step: while locked, switch to period 6.
  - Next capture gives period=6, locked=0, err_cnt=1.
  - Return to period 4: locked again after 3 captures.
- Stop: hold clk_in=0 while locked.
  - timeout=1 and locked=0 once cnt hits 255.
  - Restart: timeout clears on the first rise and no capture occurs on that rise; lock is reached after 3 further in-band captures.
- Tolerance: TOL=1, period alternates 3/5.
  - All in-band, locked asserts. Period 6 breaks lock.
- Reset: assert rst low mid-period.
  - All outputs 0 immediately.
  - After release, first edge gives no meas_valid; the second edge captures.
- Duty (macro defined): period 4 with high 1 for one period.
  - duty_err=1, locked drops, err_cnt increments.
  - Without the macro: duty_err stays 0 and lock holds.
